// File: rtl/clk_div_multi.sv
// Multi-channel programmable clock divider: each channel divides clk_in by a
// runtime-loadable divisor, with glitch-free stop, deferred reload and global realign.
module clk_div_multi #(
  parameter int NUM_CH      = 2,
  parameter int CNT_W       = 21,
  parameter int DEFAULT_DIV = 10
) (
  input  logic                    clk_in,
  input  logic                    rst_n,
  input  logic [NUM_CH-1:0]       en,
  input  logic [NUM_CH*CNT_W-1:0] div_val,
  input  logic [NUM_CH-1:0]       div_load,
  input  logic                    sync,
  output logic [NUM_CH-1:0]       clk_out,
  output logic [NUM_CH-1:0]       tick,
  output logic [NUM_CH-1:0]       div_err
);

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_RUN  = 2'd1,
    ST_STOP = 2'd2
  } state_t;

  localparam logic [CNT_W-1:0] LP_DEF_DIV = CNT_W'(DEFAULT_DIV);

  for (genvar g = 0; g < NUM_CH; g++) begin : g_ch
    state_t           r_state;
    logic [CNT_W-1:0] r_idx;
    logic [CNT_W-1:0] r_div;
    logic [CNT_W-1:0] r_pend;
    logic             r_pend_vld;
    logic             r_clk;
    logic             r_tick;
    logic             r_err;

    logic [CNT_W-1:0] w_val;
    logic [CNT_W-1:0] w_next;
    logic [CNT_W-1:0] w_half;
    logic             w_wrap;
    logic             w_ld_ok;
    logic             w_ld_bad;
    logic             w_apply;

    assign w_val    = div_val[g*CNT_W +: CNT_W];
    assign w_ld_ok  = div_load[g] && (w_val >= CNT_W'(2));
    assign w_ld_bad = div_load[g] && (w_val <  CNT_W'(2));
    assign w_wrap   = (r_idx == (r_div - CNT_W'(1)));
    assign w_next   = w_wrap ? '0 : (r_idx + CNT_W'(1));
    // ceil(N/2) without needing an extra carry bit
    assign w_half   = (r_div >> 1) + {{(CNT_W-1){1'b0}}, r_div[0]};

    // Edges on which a pending divisor may be promoted to active
    always_comb begin
      w_apply = 1'b0;
      case (r_state)
        ST_IDLE: w_apply = en[g];
        ST_RUN:  w_apply = sync | w_wrap;
        ST_STOP: w_apply = !sync && w_wrap;
        default: w_apply = 1'b0;
      endcase
    end

    always_ff @(posedge clk_in) begin
      if (w_ld_ok) r_pend <= w_val;
    end

    always_ff @(posedge clk_in or negedge rst_n) begin
      if (!rst_n) begin
        r_state    <= ST_IDLE;
        r_idx      <= '0;
        r_div      <= LP_DEF_DIV;
        r_pend_vld <= 1'b0;
        r_clk      <= 1'b0;
        r_tick     <= 1'b0;
        r_err      <= 1'b0;
      end else begin
        r_err <= w_ld_bad;
        // A load on the promotion edge survives as the next pending value
        if (w_ld_ok)      r_pend_vld <= 1'b1;
        else if (w_apply) r_pend_vld <= 1'b0;
        if (w_apply && r_pend_vld) r_div <= r_pend;

        case (r_state)
          ST_IDLE: begin
            if (en[g]) begin
              r_state <= ST_RUN;
              r_idx   <= '0;
              r_clk   <= 1'b1;
              r_tick  <= 1'b1;
            end else begin
              r_idx   <= '0;
              r_clk   <= 1'b0;
              r_tick  <= 1'b0;
            end
          end
          ST_RUN: begin
            if (sync) begin
              r_idx  <= '0;
              r_clk  <= 1'b1;
              r_tick <= 1'b1;
            end else begin
              r_idx  <= w_next;
              r_clk  <= (w_next < w_half);
              r_tick <= w_wrap;
              if (!en[g]) r_state <= ST_STOP;
            end
          end
          ST_STOP: begin
            if (sync || (!en[g] && w_wrap)) begin
              r_state <= ST_IDLE;
              r_idx   <= '0;
              r_clk   <= 1'b0;
              r_tick  <= 1'b0;
            end else begin
              r_idx  <= w_next;
              r_clk  <= (w_next < w_half);
              r_tick <= w_wrap;
              if (en[g]) r_state <= ST_RUN;
            end
          end
          default: begin
            r_state <= ST_IDLE;
            r_idx   <= '0;
            r_clk   <= 1'b0;
            r_tick  <= 1'b0;
          end
        endcase
      end
    end

    assign clk_out[g] = r_clk;
    assign tick[g]    = r_tick;
    assign div_err[g] = r_err;
  end

endmodule

// File: tb/tb_clk_div_multi.sv
// Directed bench for clk_div_multi: stimulus queues the expected outputs of
// every edge, and an independent monitor pops and compares them.
module tb_clk_div_multi;
  localparam int NCH = 2;
  localparam int CW  = 8;

  logic              clk_in;
  logic              rst_n;
  logic [NCH-1:0]    en;
  logic [NCH*CW-1:0] div_val;
  logic [NCH-1:0]    div_load;
  logic              sync;
  logic [NCH-1:0]    clk_out;
  logic [NCH-1:0]    tick;
  logic [NCH-1:0]    div_err;

  typedef struct {
    string      nm;
    logic [1:0] c;
    logic [1:0] t;
    logic [1:0] e;
  } exp_t;

  exp_t q[$];
  int   n_chk = 0;
  int   n_err = 0;
  event chk_now;

  clk_div_multi #(.NUM_CH(NCH), .CNT_W(CW), .DEFAULT_DIV(10)) dut (
    .clk_in  (clk_in),
    .rst_n   (rst_n),
    .en      (en),
    .div_val (div_val),
    .div_load(div_load),
    .sync    (sync),
    .clk_out (clk_out),
    .tick    (tick),
    .div_err (div_err)
  );

  initial clk_in = 1'b0;
  always #5 clk_in = ~clk_in;

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached, queue=%0d", q.size());
    $fatal(1, "watchdog");
  end

  // Monitor: compares whatever the stimulus side has queued
  initial begin
    exp_t x;
    forever begin
      @(negedge clk_in or chk_now);
      if (q.size() != 0) begin
        x = q.pop_front();
        n_chk++;
        if (clk_out !== x.c || tick !== x.t || div_err !== x.e) begin
          n_err++;
          $display("FAIL %s: got clk_out=%b tick=%b div_err=%b, want clk_out=%b tick=%b div_err=%b",
                   x.nm, clk_out, tick, div_err, x.c, x.t, x.e);
        end
      end
    end
  end

  task automatic push(string nm, logic [1:0] c, logic [1:0] t, logic [1:0] e);
    exp_t x;
    x.nm = nm; x.c = c; x.t = t; x.e = e;
    q.push_back(x);
  endtask

  // One clock edge: strobes self-clear, expectation for the post-edge outputs is queued
  task automatic cyc(string nm, logic [1:0] c, logic [1:0] t, logic [1:0] e);
    @(posedge clk_in);
    #1;
    div_load = '0;
    sync     = 1'b0;
    push(nm, c, t, e);
    @(negedge clk_in);
    #1;
  endtask

  task automatic seg(string nm, int n, bit cv, bit tk, bit er);
    for (int i = 0; i < n; i++)
      cyc(nm, {1'b0, cv}, {1'b0, tk && (i == 0)}, {1'b0, er && (i == 0)});
  endtask

  task automatic per(string nm, int hi, int lo);
    seg(nm, hi, 1'b1, 1'b1, 1'b0);
    seg(nm, lo, 1'b0, 1'b0, 1'b0);
  endtask

  task automatic load(int ch, int val);
    div_val[ch*CW +: CW] = CW'(val);
    div_load[ch]         = 1'b1;
  endtask

  initial begin
    logic [1:0] c, t;
    rst_n = 1'b0; en = '0; div_val = '0; div_load = '0; sync = 1'b0;

    for (int i = 0; i < 3; i++) cyc("reset_state", 2'b00, 2'b00, 2'b00);
    rst_n = 1'b1;

    // Default divisor 10: 5 high / 5 low, tick on first enabled edge
    en[0] = 1'b1;
    per("div10_p1", 5, 5);
    per("div10_p2", 5, 5);

    // Load 5 while idx=3: current 10-cycle period completes first
    seg("ld5_pre", 4, 1'b1, 1'b1, 1'b0);
    load(0, 5);
    seg("ld5_idx4", 1, 1'b1, 1'b0, 1'b0);
    seg("ld5_low", 5, 1'b0, 1'b0, 1'b0);
    per("div5_p1", 3, 2);
    per("div5_p2", 3, 2);
    // Load on the boundary edge waits one whole period
    load(0, 7);
    per("ld7_boundary", 3, 2);
    per("div7_p1", 4, 3);

    // Rejected loads of 1 and 0
    load(0, 1);
    seg("err1_edge", 1, 1'b1, 1'b1, 1'b1);
    seg("err1_hi", 3, 1'b1, 1'b0, 1'b0);
    seg("err1_lo", 3, 1'b0, 1'b0, 1'b0);
    load(0, 0);
    seg("err0_edge", 1, 1'b1, 1'b1, 1'b1);
    seg("err0_hi", 3, 1'b1, 1'b0, 1'b0);
    seg("err0_lo", 3, 1'b0, 1'b0, 1'b0);
    per("div7_kept", 4, 3);

    // Divisor 8, en dropped at idx=2: finish 4/4 then stay low
    load(0, 8);
    per("ld8_boundary", 4, 3);
    seg("stop_hi_a", 3, 1'b1, 1'b1, 1'b0);
    en[0] = 1'b0;
    seg("stop_hi_b", 1, 1'b1, 1'b0, 1'b0);
    seg("stop_lo", 4, 1'b0, 1'b0, 1'b0);
    seg("stopped_idle", 3, 1'b0, 1'b0, 1'b0);
    en[0] = 1'b1;
    per("restart8", 4, 4);
    // Re-enable while STOPPING: waveform unbroken
    seg("rerun_a", 2, 1'b1, 1'b1, 1'b0);
    en[0] = 1'b0;
    seg("rerun_b", 2, 1'b1, 1'b0, 1'b0);
    seg("rerun_c", 1, 1'b0, 1'b0, 1'b0);
    en[0] = 1'b1;
    seg("rerun_d", 3, 1'b0, 1'b0, 1'b0);
    per("rerun_next", 4, 4);

    // Two channels, then sync realign with a pending divisor on ch0
    load(0, 6);
    load(1, 9);
    cyc("mc_load", 2'b01, 2'b01, 2'b00);
    en[1] = 1'b1;
    cyc("mc_ch1_start", 2'b11, 2'b10, 2'b00);
    cyc("mc_run_a", 2'b11, 2'b00, 2'b00);
    cyc("mc_run_b", 2'b11, 2'b00, 2'b00);
    sync = 1'b1;
    cyc("sync_align", 2'b11, 2'b11, 2'b00);
    for (int k = 1; k <= 18; k++) begin
      c = {((k % 9) < 5) ? 1'b1 : 1'b0, ((k % 6) < 3) ? 1'b1 : 1'b0};
      t = {((k % 9) == 0) ? 1'b1 : 1'b0, ((k % 6) == 0) ? 1'b1 : 1'b0};
      cyc("sync_run", c, t, 2'b00);
    end
    en[1] = 1'b0;
    cyc("ch1_stopping", 2'b11, 2'b00, 2'b00);
    sync = 1'b1;
    cyc("sync_stop_idle", 2'b01, 2'b01, 2'b00);
    sync = 1'b1;
    cyc("sync_idle_noeff", 2'b01, 2'b01, 2'b00);
    cyc("post_sync", 2'b01, 2'b00, 2'b00);

    // Asynchronous reset in the middle of a high phase
    rst_n = 1'b0;
    #1;
    push("async_reset", 2'b00, 2'b00, 2'b00);
    ->chk_now;
    #1;
    en = '0;
    cyc("reset_hold", 2'b00, 2'b00, 2'b00);
    rst_n = 1'b1;
    en[0] = 1'b1;
    per("default_after_rst", 5, 5);
    per("default_after_rst2", 5, 5);

    for (int i = 0; i < 50 && q.size() != 0; i++) @(negedge clk_in);
    #1;
    if (q.size() != 0) begin
      n_chk++;
      n_err++;
      $display("FAIL drain: %0d expectations never compared, want 0", q.size());
    end
    $display("Result: errors=%0d of %0d checks", n_err, n_chk);
    $finish;
  end
endmodule

// File: doc/clk_div_multi.md
CLK_DIV_MULTI -- requirements
Module: clk_div_multi

Interface
REQ-001 The block SHALL have parameter NUM_CH, default 2, giving the number of independent divider channels (1..8).
REQ-002 The block SHALL have parameter CNT_W, default 21, giving the divisor and counter width in bits.
REQ-003 The block SHALL have parameter DEFAULT_DIV, default 10, giving the divisor loaded into every channel at reset; it must be at least 2.
REQ-004 The block SHALL have port clk_in, input, 1 bit: the single clock; all logic uses its rising edge.
REQ-005 The block SHALL have port rst_n, input, 1 bit: asynchronous, active-low reset.
REQ-006 The block SHALL have port en, input, NUM_CH bits: per-channel run enable.
REQ-007 The block SHALL have port div_val, input, NUM_CH*CNT_W bits: channel i divisor is div_val[i*CNT_W +: CNT_W].
REQ-008 The block SHALL have port div_load, input, NUM_CH bits: per-channel single-cycle divisor load strobe.
REQ-009 The block SHALL have port sync, input, 1 bit: global phase-realign strobe.
REQ-010 The block SHALL have port clk_out, output, NUM_CH bits: registered divided clocks.
REQ-011 The block SHALL have port tick, output, NUM_CH bits: one-cycle pulse, high in the first clk_in cycle of each clk_out high phase.
REQ-012 The block SHALL have port div_err, output, NUM_CH bits: one-cycle pulse flagging a rejected load.

Function (per channel; N = active divisor, H = ceil(N/2))
REQ-013 Each channel SHALL have states IDLE, RUN and STOPPING, an index counter idx (0..N-1), an active divisor and a pending divisor with a valid flag.
REQ-014 In RUN, at each edge, next idx SHALL be (idx==N-1) ? 0 : idx+1.
REQ-015 In RUN, at each edge, clk_out SHALL be loaded with (next idx < H) and tick SHALL be loaded with (next idx == 0).
REQ-016 clk_out period SHALL be N cycles with H cycles high and N-H cycles low (N=5 gives 3 high, 2 low).
REQ-017 In IDLE, idx, clk_out and tick SHALL be 0.
REQ-018 An edge with en=1 in IDLE SHALL move the channel to RUN and set idx=0, clk_out=1, tick=1; any pending divisor SHALL become active at that edge.
REQ-019 An edge with en=0 in RUN SHALL move the channel to STOPPING; counting continues.
REQ-020 In STOPPING, the edge where next idx would be 0 SHALL move the channel to IDLE with clk_out=0 and tick=0, so no truncated high phase occurs.
REQ-021 An edge with en=1 in STOPPING SHALL return the channel to RUN with no phase disturbance.
REQ-022 div_load with div_val >= 2 SHALL write the pending divisor and set the valid flag; a later load before it is applied SHALL overwrite it.
REQ-023 div_load with div_val of 0 or 1 SHALL be ignored and SHALL assert div_err for exactly the next cycle.
REQ-024 A valid pending divisor SHALL become active only at the period boundary edge (next idx == 0), and the valid flag SHALL then clear.
REQ-025 A load occurring on a boundary edge SHALL apply at the following boundary, not the current one.
REQ-026 sync=1 SHALL restart each channel in RUN with idx=0, clk_out=1 and tick=1, applying any pending divisor.
REQ-027 sync=1 SHALL send each channel in STOPPING directly to IDLE.
REQ-028 sync=1 SHALL have no effect on channels in IDLE.
REQ-029 sync SHALL take priority over the normal boundary and en handling on the same edge.
REQ-030 Channels SHALL be fully independent except for sync, and no output SHALL be combinational from any input.

Reset
REQ-031 rst_n=0 SHALL asynchronously force every channel to IDLE with idx=0, clk_out=0, tick=0, div_err=0, active divisor=DEFAULT_DIV and pending valid=0, including mid-period.
REQ-032 After rst_n deasserts, the first edge with en=1 SHALL behave as in REQ-018.

Verification
REQ-033 Reset, then en[0]=1 with divisor 10 -> clk_out[0] repeats 5 high/5 low, tick[0] pulses every 10 cycles starting at the first enabled edge.
REQ-034 Load 5 at idx=3 of a 10-divisor period -> the current period completes at 10 cycles, then 3 high/2 low; a load on the boundary edge is delayed one full period.
REQ-035 Load of 1 -> div_err pulses one cycle and the period stays unchanged; load 0 gives the same result.
REQ-036 en dropped at idx=2 (high phase) with divisor 8 -> the period completes at 4 high/4 low, then clk_out stays 0; en re-raised in STOPPING -> no gap in output.
REQ-037 Ch0 divisor 6 and ch1 divisor 9 running, sync pulse -> both clk_out rise together with tick on the next edge; a pending divisor is applied at that edge.
REQ-038 rst_n pulled low mid-high-phase -> clk_out drops with no clock edge, and the divisor returns to DEFAULT_DIV.
